// File: rtl/tdr_seq_ctrl.sv
// rtl/tdr_seq_ctrl.sv - TDR bank sequencer: clear, launch, capture window, decode, valid/ready result.
// Optional TDR_BUBBLE_CHECK_EN: leading-ones decode with bubble detection (default: popcount).
module tdr_seq_ctrl #(
  parameter int N_CELLS = 16,
  parameter int CNT_W   = $clog2(N_CELLS + 1),
  parameter int WIN_W   = 8
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               start,
  input  logic               abort,
  input  logic [WIN_W-1:0]   win_len,
  input  logic [N_CELLS-1:0] tdr_carry,
  output logic               cell_rstb,
  output logic               launch,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CNT_W-1:0]   res_count,
  output logic               res_full,
  output logic               bubble_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LAUNCH, S_WAIT, S_SYNC, S_CAPTURE, S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic               ph_q, ph_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [N_CELLS-1:0] sync1_q, sync2_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               full_q, full_d;
  logic               bub_q, bub_d;
  logic [CNT_W-1:0]   dec_cnt;
  logic               dec_bub;

  // Free-running synchronizer for the asynchronous carry vector
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= tdr_carry;
      sync2_q <= sync1_q;
    end
  end

`ifdef TDR_BUBBLE_CHECK_EN
  always_comb begin
    logic seen_zero;
    seen_zero = 1'b0;
    dec_cnt   = '0;
    dec_bub   = 1'b0;
    for (int i = 0; i < N_CELLS; i++) begin
      if (!sync2_q[i])    seen_zero = 1'b1;
      else if (seen_zero) dec_bub   = 1'b1;
      else                dec_cnt   = dec_cnt + 1'b1;
    end
  end
`else
  always_comb begin
    dec_cnt = '0;
    dec_bub = 1'b0;
    for (int i = 0; i < N_CELLS; i++) begin
      dec_cnt = dec_cnt + CNT_W'(sync2_q[i]);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    bub_d   = bub_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          win_d   = (win_len == '0) ? WIN_W'(1) : win_len;
          ph_d    = 1'b0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        ph_d = ~ph_q;
        if (ph_q) state_d = S_LAUNCH;
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        // Counter ends at zero when the window expires
        win_d = win_q - 1'b1;
        if (win_q == WIN_W'(1)) state_d = S_SYNC;
      end
      S_SYNC: begin
        ph_d = ~ph_q;
        if (ph_q) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        cnt_d   = dec_cnt;
        full_d  = &sync2_q;
        bub_d   = dec_bub;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything outside IDLE, including a pending handshake
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      ph_d    = 1'b0;
      win_d   = '0;
      cnt_d   = cnt_q;
      full_d  = full_q;
      bub_d   = bub_q;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      ph_q    <= 1'b0;
      win_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      bub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      bub_q   <= bub_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign launch     = (state_q == S_LAUNCH);
  assign res_valid  = (state_q == S_HOLD);
  assign cell_rstb  = (state_q != S_IDLE) && (state_q != S_CLEAR);
  assign res_count  = cnt_q;
  assign res_full   = full_q;
  assign bubble_err = bub_q;

endmodule

// File: tb/tb_tdr_seq_ctrl.sv
// tb/tb_tdr_seq_ctrl.sv - table-driven and sequence checks for tdr_seq_ctrl.
module tb_tdr_seq_ctrl;

  logic        clk = 1'b0;
  logic        rstb, start, abort, res_ready;
  logic [7:0]  win_len;
  logic [15:0] tdr_carry;
  logic        cell_rstb, launch, busy, res_valid, res_full, bubble_err;
  logic [4:0]  res_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tdr_seq_ctrl dut (
    .clk(clk), .rstb(rstb), .start(start), .abort(abort), .win_len(win_len),
    .tdr_carry(tdr_carry), .cell_rstb(cell_rstb), .launch(launch), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count),
    .res_full(res_full), .bubble_err(bubble_err)
  );

  typedef struct {
    logic [7:0]  wl;
    logic [15:0] cv;
    logic [4:0]  cnt;
    logic        full;
    logic        bub;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Starts a measurement; returns at the negedge after the start edge
  task automatic kick(input logic [7:0] wl, input logic [15:0] cv);
    tdr_carry = cv;
    win_len   = wl;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_valid_seen"}, res_valid, 1'b1);
  endtask

  task automatic measure(input int idx);
    int w, lerr, verr;
    w = (vecs[idx].wl == 0) ? 1 : int'(vecs[idx].wl);
    kick(vecs[idx].wl, vecs[idx].cv);
    lerr = 0;
    verr = 0;
    // k = number of edges after the start edge
    for (int k = 0; k <= 6 + w; k++) begin
      if (launch !== (k == 2)) lerr++;
      if (res_valid !== (k == 6 + w)) verr++;
      if (k < 6 + w) @(negedge clk);
    end
    chk($sformatf("v%0d_launch_timing", idx), lerr, 0);
    chk($sformatf("v%0d_valid_timing", idx), verr, 0);
    chk($sformatf("v%0d_count", idx), res_count, vecs[idx].cnt);
    chk($sformatf("v%0d_full", idx), res_full, vecs[idx].full);
    chk($sformatf("v%0d_bubble", idx), bubble_err, vecs[idx].bub);
    chk($sformatf("v%0d_hold_cell_rstb", idx), cell_rstb, 1'b1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk($sformatf("v%0d_post_valid", idx), res_valid, 1'b0);
    chk($sformatf("v%0d_post_busy", idx), busy, 1'b0);
    chk($sformatf("v%0d_post_cell_rstb", idx), cell_rstb, 1'b0);
  endtask

  initial begin
    int bad;
    vecs[0] = '{8'd4,   16'h00FF, 5'd8,  1'b0, 1'b0};
    vecs[1] = '{8'd3,   16'hFFFF, 5'd16, 1'b1, 1'b0};
    vecs[2] = '{8'd5,   16'h0000, 5'd0,  1'b0, 1'b0};
    vecs[3] = '{8'd0,   16'h0001, 5'd1,  1'b0, 1'b0};
`ifdef TDR_BUBBLE_CHECK_EN
    vecs[4] = '{8'd2,   16'h0017, 5'd3,  1'b0, 1'b1};
    vecs[5] = '{8'd1,   16'h00F0, 5'd0,  1'b0, 1'b1};
`else
    vecs[4] = '{8'd2,   16'h0017, 5'd4,  1'b0, 1'b0};
    vecs[5] = '{8'd1,   16'h00F0, 5'd4,  1'b0, 1'b0};
`endif
    vecs[6] = '{8'd255, 16'h7FFF, 5'd15, 1'b0, 1'b0};

    rstb = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    win_len = 8'd0; tdr_carry = 16'h0;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {cell_rstb, launch, busy, res_valid, res_full, bubble_err, res_count}, 11'd0);

    for (int i = 0; i < 7; i++) measure(i);

    // Backpressure: result stays stable and start is ignored
    kick(8'd2, 16'h0003);
    wait_valid("bp");
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      start = c[0];
      tdr_carry = 16'hFFFF;
      @(negedge clk);
      if (res_valid !== 1'b1 || res_count !== 5'd2 || res_full !== 1'b0 || launch !== 1'b0) bad++;
    end
    start = 1'b0;
    chk("bp_stable", bad, 0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("bp_release_idle", busy, 1'b0);

    // Abort during WAIT: no result, registers keep the previous result
    kick(8'd8, 16'h000F);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_wait_idle", {busy, cell_rstb, res_valid}, 3'b000);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) bad++;
    end
    chk("abort_wait_no_valid", bad, 0);
    chk("abort_wait_count_kept", res_count, 5'd2);

    // Abort together with res_ready in HOLD
    kick(8'd1, 16'hFFFF);
    wait_valid("ab_hold");
    abort = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    res_ready = 1'b0;
    chk("abort_hold_idle", {busy, res_valid, cell_rstb}, 3'b000);

    // start and abort together in IDLE: start wins
    tdr_carry = 16'h0007;
    win_len = 8'd1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_beats_abort", busy, 1'b1);
    wait_valid("sa");
    chk("sa_count", res_count, 5'd3);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;

    // Asynchronous reset mid-WAIT, then a normal measurement
    kick(8'd8, 16'h00FF);
    repeat (4) @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    chk("async_reset", {cell_rstb, launch, busy, res_valid, res_full, bubble_err, res_count}, 11'd0);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    measure(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
